imm_gen_stage: RTL and testbench



---
 rtl/imm_gen_stage.sv | 212 +++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: decodes RV32I/RV64I immediate formats and
// hands results to the ALU operand mux through a 2-entry valid/ready buffer.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SHI = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;

  // ---------------------------------------------------------------------------
  // Immediate decode
  // ---------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic            w_is_shift;
  logic [31:0]     w_imm_i32, w_imm_s32, w_imm_b32, w_imm_u32, w_imm_j32;
  logic [XLEN-1:0] w_shamt, w_shamt_w;
  entry_t          w_entry;

  assign w_opcode   = in_instr[6:0];
  assign w_is_shift = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);

  // Each format is first assembled as a sign-correct 32-bit value, then widened.
  assign w_imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u32 = {in_instr[31:12], 12'b0};
  assign w_imm_j32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

  assign w_shamt   = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign w_shamt_w = XLEN'(in_instr[24:20]);

  // NOTE: every field gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_entry.imm     = '0;
    w_entry.fmt     = FMT_ILL;
    w_entry.illegal = 1'b1;
    w_entry.tag     = in_tag;
    case (w_opcode)
      OP_IMM: begin
        w_entry.illegal = 1'b0;
        if (w_is_shift) begin
          w_entry.fmt = FMT_SHI;
          w_entry.imm = w_shamt;
        end else begin
          w_entry.fmt = FMT_I;
          w_entry.imm = XLEN'($signed(w_imm_i32));
        end
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          w_entry.illegal = 1'b0;
          if (w_is_shift) begin
            w_entry.fmt = FMT_SHI;
            w_entry.imm = w_shamt_w;
          end else begin
            w_entry.fmt = FMT_I;
            w_entry.imm = XLEN'($signed(w_imm_i32));
          end
        end
      end
      OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        w_entry.illegal = 1'b0;
        w_entry.fmt     = FMT_I;
        w_entry.imm     = XLEN'($signed(w_imm_i32));
      end
      OP_STORE: begin
        w_entry.illegal = 1'b0;
        w_entry.fmt     = FMT_S;
        w_entry.imm     = XLEN'($signed(w_imm_s32));
      end
      OP_BRANCH: begin
        w_entry.illegal = 1'b0;
        w_entry.fmt     = FMT_B;
        w_entry.imm     = XLEN'($signed(w_imm_b32));
      end
      OP_LUI, OP_AUIPC: begin
        w_entry.illegal = 1'b0;
        w_entry.fmt     = FMT_U;
        w_entry.imm     = XLEN'($signed(w_imm_u32));
      end
      OP_JAL: begin
        w_entry.illegal = 1'b0;
        w_entry.fmt     = FMT_J;
        w_entry.imm     = XLEN'($signed(w_imm_j32));
      end
      OP_OP: begin
        w_entry.illegal = 1'b0;
        w_entry.fmt     = FMT_R;
      end
      OP_OP_32: begin
        if (XLEN == 64) begin
          w_entry.illegal = 1'b0;
          w_entry.fmt     = FMT_R;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry output buffer: r_head drives the outputs, r_tail holds the second
  // ---------------------------------------------------------------------------
  entry_t     r_head, r_tail;
  logic [1:0] r_count;
  logic       w_push, w_pop;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // NOTE: the entry registers are reset as well as the count because the head
  // entry is the output port and must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_entry;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_entry;
          end else if (w_push) begin
            r_tail  <= w_entry;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          // Full: in_ready is low, so only a pop can happen here.
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  // Counts illegal pushes even in a flush cycle; flush never clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= 16'd0;
    end else if (w_push && w_entry.illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  assign out_imm     = r_head.imm;
  assign out_fmt     = r_head.fmt;
  assign out_illegal = r_head.illegal;
  assign out_tag     = r_head.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;

  logic        f32, v32, ro32, rdy32, ov32, ill32;
  logic [31:0] i32;
  logic [7:0]  t32, otag32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;

  logic        f64, v64, ro64, rdy64, ov64, ill64;
  logic [31:0] i64;
  logic [7:0]  t64, otag64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(f32),
    .in_valid(v32), .in_ready(rdy32), .in_instr(i32), .in_tag(t32),
    .out_valid(ov32), .out_ready(ro32), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_tag(otag32), .illegal_cnt(cnt32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(f64),
    .in_valid(v64), .in_ready(rdy64), .in_instr(i64), .in_tag(t64),
    .out_valid(ov64), .out_ready(ro64), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_tag(otag64), .illegal_cnt(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f32 = 0; v32 = 1; ro32 = 1; i32 = 32'hFFF00093; t32 = 8'h55;
    f64 = 0; v64 = 1; ro64 = 1; i64 = 32'hFFF00093; t64 = 8'h55;
    repeat (3) step();
    n_checks++; if (rdy32 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", rdy32); end
    n_checks++; if (ov32 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", ov32); end
    n_checks++; if (cnt32 !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt32); end
    n_checks++; if ({imm32, fmt32, ill32, otag32} !== '0) begin n_bad++;
      $display("FAIL reset_outputs got imm=%h fmt=%0d ill=%b tag=%h exp all zero", imm32, fmt32, ill32, otag32); end
    n_checks++; if (ov64 !== 1'b0 || imm64 !== 64'd0 || rdy64 !== 1'b1) begin n_bad++;
      $display("FAIL reset_dut64 got ov=%b imm=%h rdy=%b exp ov=0 imm=0 rdy=1", ov64, imm64, rdy64); end
    v32 = 0; v64 = 0;
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0) begin n_bad++;
      $display("FAIL reset_no_push got ov32=%b ov64=%b exp 0 0", ov32, ov64); end
  endtask

  task automatic test_decode32();
    vec_t tbl[14];
    tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0};
    tbl[1]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0};
    tbl[2]  = '{32'h12345037, 64'h12345000, 3'd4, 1'b0};
    tbl[3]  = '{32'h00112623, 64'h0000000C, 3'd2, 1'b0};
    tbl[4]  = '{32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 1'b0};
    tbl[5]  = '{32'h03F09093, 64'h0000001F, 3'd6, 1'b0};
    tbl[6]  = '{32'h4010D093, 64'h00000001, 3'd6, 1'b0};
    tbl[7]  = '{32'h002081B3, 64'h00000000, 3'd0, 1'b0};
    tbl[8]  = '{32'h0020803B, 64'h00000000, 3'd7, 1'b1};
    tbl[9]  = '{32'hFFF0809B, 64'h00000000, 3'd7, 1'b1};
    tbl[10] = '{32'hFFFFF097, 64'hFFFFF000, 3'd4, 1'b0};
    tbl[11] = '{32'h8000A083, 64'hFFFFF800, 3'd1, 1'b0};
    tbl[12] = '{32'h0000007F, 64'h00000000, 3'd7, 1'b1};
    tbl[13] = '{32'hFE112FA3, 64'hFFFFFFFF, 3'd2, 1'b0};
    ro32 = 1;
    for (int k = 0; k < 14; k++) begin
      v32 = 1; i32 = tbl[k].instr; t32 = 8'(k + 16);
      step();
      n_checks++;
      if (ov32 !== 1'b1 || imm32 !== tbl[k].imm[31:0] || fmt32 !== tbl[k].fmt ||
          ill32 !== tbl[k].ill || otag32 !== 8'(k + 16)) begin
        n_bad++;
        $display("FAIL dec32[%0d] instr=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h exp v=1 imm=%h fmt=%0d ill=%b tag=%h",
                 k, tbl[k].instr, ov32, imm32, fmt32, ill32, otag32,
                 tbl[k].imm[31:0], tbl[k].fmt, tbl[k].ill, 8'(k + 16));
      end
    end
    v32 = 0;
    step();
    n_checks++; if (ov32 !== 1'b0) begin n_bad++; $display("FAIL dec32_drain got=%b exp=0", ov32); end
    n_checks++; if (cnt32 !== 16'd3) begin n_bad++; $display("FAIL dec32_cnt got=%0d exp=3", cnt32); end
  endtask

  task automatic test_decode64();
    vec_t tbl[10];
    tbl[0] = '{32'h03F09093, 64'h000000000000003F, 3'd6, 1'b0};
    tbl[1] = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    tbl[2] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    tbl[3] = '{32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    tbl[4] = '{32'h01F0909B, 64'h000000000000001F, 3'd6, 1'b0};
    tbl[5] = '{32'h0020803B, 64'h0000000000000000, 3'd0, 1'b0};
    tbl[6] = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    tbl[7] = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
    tbl[8] = '{32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1};
    tbl[9] = '{32'h12345037, 64'h0000000012345000, 3'd4, 1'b0};
    ro64 = 1;
    for (int k = 0; k < 10; k++) begin
      v64 = 1; i64 = tbl[k].instr; t64 = 8'(k + 64);
      step();
      n_checks++;
      if (ov64 !== 1'b1 || imm64 !== tbl[k].imm || fmt64 !== tbl[k].fmt ||
          ill64 !== tbl[k].ill || otag64 !== 8'(k + 64)) begin
        n_bad++;
        $display("FAIL dec64[%0d] instr=%h got v=%b imm=%h fmt=%0d ill=%b tag=%h exp v=1 imm=%h fmt=%0d ill=%b tag=%h",
                 k, tbl[k].instr, ov64, imm64, fmt64, ill64, otag64,
                 tbl[k].imm, tbl[k].fmt, tbl[k].ill, 8'(k + 64));
      end
    end
    v64 = 0;
    step();
    n_checks++; if (ov64 !== 1'b0 || cnt64 !== 16'd1) begin n_bad++;
      $display("FAIL dec64_drain got ov=%b cnt=%0d exp ov=0 cnt=1", ov64, cnt64); end
  endtask

  task automatic test_back_to_back();
    ro32 = 0; v32 = 1; i32 = 32'h00100093;
    t32 = 8'd1; step();
    n_checks++; if (ov32 !== 1'b1 || otag32 !== 8'd1 || rdy32 !== 1'b1) begin n_bad++;
      $display("FAIL bp_first got v=%b tag=%0d rdy=%b exp v=1 tag=1 rdy=1", ov32, otag32, rdy32); end
    t32 = 8'd2; step();
    n_checks++; if (rdy32 !== 1'b0 || otag32 !== 8'd1) begin n_bad++;
      $display("FAIL bp_full got rdy=%b tag=%0d exp rdy=0 tag=1", rdy32, otag32); end
    t32 = 8'd3; step(); step();
    n_checks++; if (rdy32 !== 1'b0 || ov32 !== 1'b1 || otag32 !== 8'd1 || imm32 !== 32'd1) begin n_bad++;
      $display("FAIL bp_hold got rdy=%b v=%b tag=%0d imm=%h exp rdy=0 v=1 tag=1 imm=1", rdy32, ov32, otag32, imm32); end
    ro32 = 1; step();
    n_checks++; if (otag32 !== 8'd2 || rdy32 !== 1'b1 || ov32 !== 1'b1) begin n_bad++;
      $display("FAIL bp_pop1 got tag=%0d rdy=%b v=%b exp tag=2 rdy=1 v=1", otag32, rdy32, ov32); end
    step();
    n_checks++; if (otag32 !== 8'd3 || ov32 !== 1'b1) begin n_bad++;
      $display("FAIL bp_pop2 got tag=%0d v=%b exp tag=3 v=1", otag32, ov32); end
    v32 = 0; step();
    n_checks++; if (ov32 !== 1'b0) begin n_bad++;
      $display("FAIL bp_no_dup got v=%b tag=%0d exp v=0", ov32, otag32); end
  endtask

  task automatic test_illegal_flush();
    rst_n = 1'b0; #2 rst_n = 1'b1;
    ro32 = 0; v32 = 1; i32 = 32'h0000007F; t32 = 8'hA1;
    step();
    n_checks++; if (ov32 !== 1'b1 || fmt32 !== 3'd7 || ill32 !== 1'b1 || imm32 !== 32'd0 || cnt32 !== 16'd1) begin n_bad++;
      $display("FAIL ill_first got v=%b fmt=%0d ill=%b imm=%h cnt=%0d exp 1 7 1 0 1", ov32, fmt32, ill32, imm32, cnt32); end
    t32 = 8'hA2; step();
    n_checks++; if (cnt32 !== 16'd2 || rdy32 !== 1'b0 || otag32 !== 8'hA1) begin n_bad++;
      $display("FAIL ill_second got cnt=%0d rdy=%b tag=%h exp cnt=2 rdy=0 tag=a1", cnt32, rdy32, otag32); end
    v32 = 0; ro32 = 1; step();
    n_checks++; if (otag32 !== 8'hA2 || fmt32 !== 3'd7 || ill32 !== 1'b1 || ov32 !== 1'b1) begin n_bad++;
      $display("FAIL ill_pop got tag=%h fmt=%0d ill=%b v=%b exp a2 7 1 1", otag32, fmt32, ill32, ov32); end
    ro32 = 0; f32 = 1; step(); f32 = 0;
    n_checks++; if (ov32 !== 1'b0 || rdy32 !== 1'b1 || cnt32 !== 16'd2) begin n_bad++;
      $display("FAIL flush got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=2", ov32, rdy32, cnt32); end
    ro32 = 1; step();
    n_checks++; if (ov32 !== 1'b0 || rdy32 !== 1'b1) begin n_bad++;
      $display("FAIL empty_ready_ignored got v=%b rdy=%b exp v=0 rdy=1", ov32, rdy32); end
    f32 = 1; v32 = 1; t32 = 8'hA3; step(); f32 = 0; v32 = 0;
    n_checks++; if (ov32 !== 1'b0 || cnt32 !== 16'd3) begin n_bad++;
      $display("FAIL flush_push got v=%b cnt=%0d exp v=0 cnt=3", ov32, cnt32); end
  endtask

  task automatic test_async_reset();
    ro32 = 0; v32 = 1; i32 = 32'hFFF00093; t32 = 8'h77;
    step(); v32 = 0;
    n_checks++; if (ov32 !== 1'b1 || imm32 !== 32'hFFFFFFFF) begin n_bad++;
      $display("FAIL areset_pre got v=%b imm=%h exp v=1 imm=ffffffff", ov32, imm32); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov32 !== 1'b0 || imm32 !== 32'd0 || fmt32 !== 3'd0 || otag32 !== 8'd0 ||
                    cnt32 !== 16'd0 || rdy32 !== 1'b1) begin n_bad++;
      $display("FAIL areset got v=%b imm=%h fmt=%0d tag=%h cnt=%0d rdy=%b exp 0 0 0 0 0 1",
               ov32, imm32, fmt32, otag32, cnt32, rdy32); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_decode64();
    test_back_to_back();
    test_illegal_flush();
    test_async_reset();
    step();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
